mips_trace_buffer: RTL and testbench
====================================

# mips_trace_buffer

Synthesizable, parametrised instruction-trace capture unit for the single-cycle MIPS core. Every enabled cycle it records the fetched PC, the instruction word, the RegWrite/ALUSrc/Branch/Jump control flags and a cycle timestamp into a DEPTH-entry circular buffer. It supports a PC-match trigger with post-trigger capture and two fill modes, and drains captured entries oldest-first over a valid/ready port. It sits beside the processor, tapping the same pc/instruction/control signals the simulation harness monitors, and makes that trace observable in hardware.

## Interface
- ADDR_W, 32, width of pc, instruction and trig_pc
- DEPTH, 16, buffer entries; power of two, >= 2
- POST_TRIG, 4, entries captured after the trigger entry; 0..DEPTH-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- cap_en  in  1  capture qualifier; 1 = current core cycle is recorded
- pc  in  ADDR_W  core PC
- instruction  in  ADDR_W  core instruction word
- reg_write, alu_src, branch, jump  in  1 each  core control flags
- mode  in  1  0 = wrap (keep last DEPTH entries), 1 = stop when full
- trig_en  in  1  enables PC-match trigger
- trig_pc  in  ADDR_W  trigger PC value
- arm  in  1  single-cycle pulse; starts a new capture
- rd_ready  in  1  consumer accepts rd_* this cycle
- rd_valid  out  1  rd_* hold a valid entry
- rd_pc, rd_instr  out  ADDR_W each  entry fields
- rd_flags  out  4  {reg_write, alu_src, branch, jump}
- rd_stamp  out  16  entry timestamp
- count  out  log2(DEPTH)+1  entries stored / remaining to read
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- triggered, overflow  out  1 each  status flags

## Operation
- Reset (rst=0): state=IDLE; wr_ptr, rd_ptr, count, stamp, post counter, triggered, overflow = 0; rd_valid=0; rd_* = 0. Buffer contents are not cleared.
- IDLE: nothing is captured. arm -> ARMED. On entry to ARMED: pointers, count, stamp, triggered and overflow are cleared.
- ARMED/POST capture: with cap_en=1, the entry {pc, instruction, flags, stamp} is written at wr_ptr. wr_ptr increments modulo DEPTH, and count increments, saturating at DEPTH.
- Wrap mode (mode=0) with count==DEPTH: a write overwrites the oldest entry and sets overflow=1 (sticky until next arm).
- Stop mode (mode=1): the write that makes count==DEPTH is the last one; state -> DONE.
- stamp: 16-bit counter, increments every clock in ARMED/POST regardless of cap_en, wraps 0xFFFF -> 0.
- Trigger (ARMED only): trig_en & cap_en & pc==trig_pc. The matching entry is written, triggered=1, and post counter=POST_TRIG. If POST_TRIG==0 -> DONE, else -> POST.
- POST: each captured write decrements the post counter; the write that reaches 0 -> DONE. Further PC matches are ignored.
- Simultaneous stop-mode full and trigger/post completion: DONE, triggered reflects the match.
- DONE: rd_ptr = (wr_ptr - count) mod DEPTH (oldest entry). rd_valid = (count != 0). On a handshake (rd_valid & rd_ready), rd_ptr increments modulo DEPTH and count decrements. No capture occurs in DONE.
- arm: accepted only in IDLE or DONE; ignored in ARMED/POST. In DONE, arm discards unread entries, and if it coincides with a handshake, arm wins and no transfer occurs.
- A trace is read once; there is no re-read without a new capture.

## Timing
- Capture is registered: an entry presented while cap_en=1 at edge N is stored at edge N, and count reflects it after N.
- State transitions take effect at the same edge as the causing write; rd_valid may assert in the first cycle state==DONE.
- rd_* are a combinational read of storage at rd_ptr, stable while rd_valid & !rd_ready.
- Throughput is one entry per clock on drain.
- Reset assertion mid-capture or mid-drain returns state to IDLE immediately (asynchronous), with rd_valid=0. Deassertion is synchronised by the integrator.

## Test plan
- Reset then idle: rst low 2 cycles, cap_en=1 for 5 cycles with no arm -> state=0, count=0, rd_valid=0, and nothing is captured.
- Stop mode fill: DEPTH=16, mode=1, arm, pc=0x00400000+4k for k=0..19 -> DONE after the 16th write, count=16. Drain with rd_ready=1 returns pc 0x00400000..0x0040003C in order, stamps 0..15. rd_valid drops after the 16th read.
- Wrap with overflow: mode=0, trig_pc=0x0040004C, POST_TRIG=4, 25 sequential PCs -> trigger at k=19, DONE after k=23, overflow=1, triggered=1. Drain yields k=8..23 (16 entries).
- Trigger with POST_TRIG=0: trig_pc=0x00400008 -> DONE at that write, count=3, last entry pc 0x00400008, flags as driven.
- Backpressure/arm collision: in DONE toggle rd_ready 1,0,1 -> rd_* are held while rd_ready=0. arm together with rd_ready=1 -> no transfer, state=ARMED, count=0.
- Async reset mid-POST: rst asserted between clock edges -> state=0, count=0, rd_valid=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: PC-triggered circular instruction-trace capture with oldest-first valid/ready drain
module mips_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_en,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [ADDR_W-1:0]          instruction,
  input  logic                       reg_write,
  input  logic                       alu_src,
  input  logic                       branch,
  input  logic                       jump,
  input  logic                       mode,
  input  logic                       trig_en,
  input  logic [ADDR_W-1:0]          trig_pc,
  input  logic                       arm,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [ADDR_W-1:0]          rd_instr,
  output logic [3:0]                 rd_flags,
  output logic [15:0]                rd_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PT   = (AW+1)'(POST_TRIG);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} st_t;
  st_t cur;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [ADDR_W-1:0] in_mem [DEPTH];
  logic [3:0]        fl_mem [DEPTH];
  logic [15:0]       st_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   post_cnt, count_n;
  logic [15:0]   stamp;
  logic wr_en, hit, fin, hs;
  assign state    = cur;
  assign wr_en    = cap_en & (cur == ARMED | cur == POST);
  assign hit      = wr_en & (cur == ARMED) & trig_en & (pc == trig_pc);
  assign count_n  = (count == FULL) ? count : count + 1'b1;
  // A write ends capture when it fills a stop-mode buffer, is a trigger with no
  // post-trigger window, or is the last post-trigger entry.
  assign fin      = wr_en & ((mode & count_n == FULL) | (hit & PT == '0) |
                             (cur == POST & post_cnt == (AW+1)'(1)));
  assign rd_valid = (cur == DONE) & (count != '0);
  assign hs       = rd_valid & rd_ready;
  assign rd_pc    = rd_valid ? pc_mem[rd_ptr] : '0;
  assign rd_instr = rd_valid ? in_mem[rd_ptr] : '0;
  assign rd_flags = rd_valid ? fl_mem[rd_ptr] : '0;
  assign rd_stamp = rd_valid ? st_mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr] <= pc;
      in_mem[wr_ptr] <= instruction;
      fl_mem[wr_ptr] <= {reg_write, alu_src, branch, jump};
      st_mem[wr_ptr] <= stamp;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stamp     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (arm && (cur == IDLE || cur == DONE)) begin
      cur       <= ARMED;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stamp     <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (cur == ARMED || cur == POST) begin
      stamp <= stamp + 16'd1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count_n;
        if (!mode && count == FULL) overflow <= 1'b1;
        if (hit) begin
          triggered <= 1'b1;
          post_cnt  <= PT;
          cur       <= POST;
        end else if (cur == POST) begin
          post_cnt <= post_cnt - 1'b1;
        end
        // Oldest entry sits count_n slots behind the post-write pointer.
        if (fin) begin
          cur    <= DONE;
          rd_ptr <= wr_ptr + 1'b1 - count_n[AW-1:0];
        end
      end
    end else if (hs) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: table-driven capture/drain checks plus backpressure, async reset and zero-post-trigger sequences
module tb_mips_trace_buffer;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic clk = 1'b0, rst = 1'b0, cap_en = 1'b0, mode = 1'b0, trig_en = 1'b0, arm = 1'b0, rd_ready = 1'b0;
  logic reg_write = 1'b0, alu_src = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] pc = '0, instruction = '0, trig_pc = '0;
  logic rd_valid, triggered, overflow, z_valid, z_trig, z_ovf;
  logic [31:0] rd_pc, rd_instr, z_pc, z_instr;
  logic [3:0] rd_flags, z_flags;
  logic [15:0] rd_stamp, z_stamp;
  logic [4:0] count, z_count;
  logic [1:0] state, z_state;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  mips_trace_buffer dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .instruction(instruction),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch), .jump(jump),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_flags(rd_flags),
    .rd_stamp(rd_stamp), .count(count), .state(state), .triggered(triggered), .overflow(overflow)
  );
  mips_trace_buffer #(.POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .instruction(instruction),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch), .jump(jump),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(z_valid), .rd_pc(z_pc), .rd_instr(z_instr), .rd_flags(z_flags),
    .rd_stamp(z_stamp), .count(z_count), .state(z_state), .triggered(z_trig), .overflow(z_ovf)
  );
  typedef struct {
    logic mode; logic trig_en; int trig_k; int n;
    int st; int cnt; logic trg; logic ovf; int first;
  } rec_t;
  rec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    cap_en = 1'b1;
    pc = BASE + 4 * kk;
    instruction = 32'h2000_0000 | kk;
    {reg_write, alu_src, branch, jump} = kk[3:0];
  endtask
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      drive(k);
      tick;
    end
    cap_en = 1'b0;
  endtask
  task automatic do_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask
  task automatic drain(input int first, input int n);
    logic [31:0] e;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = 32'(first + i);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_pc", rd_pc, BASE + 4 * e);
      chk("drain_instr", rd_instr, 32'h2000_0000 | e);
      chk("drain_flags", 32'(rd_flags), {28'd0, e[3:0]});
      chk("drain_stamp", 32'(rd_stamp), e);
      tick;
    end
    rd_ready = 1'b0;
    chk("drain_end_valid", 32'(rd_valid), 32'd0);
    chk("drain_end_count", 32'(count), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{1'b1, 1'b0, 0,  20, 3, 16, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 19, 25, 3, 16, 1'b1, 1'b1, 8};
    tbl[2] = '{1'b1, 1'b1, 3,  10, 3, 8,  1'b1, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 11, 18, 3, 16, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b1, 0,  8,  3, 5,  1'b1, 1'b0, 0};
    // reset, then capture attempts without arm
    tick;
    tick;
    chk("rst_rd_pc", rd_pc, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      drive(k);
      tick;
    end
    cap_en = 1'b0;
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_z_state", 32'(z_state), 32'd0);
    // table-driven capture scenarios
    for (int r = 0; r < 5; r++) begin
      mode = tbl[r].mode;
      trig_en = tbl[r].trig_en;
      trig_pc = BASE + 4 * 32'(tbl[r].trig_k);
      do_arm;
      chk("armed_state", 32'(state), 32'd1);
      capture(tbl[r].n);
      chk("cap_state", 32'(state), 32'(tbl[r].st));
      chk("cap_count", 32'(count), 32'(tbl[r].cnt));
      chk("cap_trig", 32'(triggered), 32'(tbl[r].trg));
      chk("cap_ovf", 32'(overflow), 32'(tbl[r].ovf));
      drain(tbl[r].first, tbl[r].cnt);
    end
    // backpressure and arm/handshake collision
    mode = 1'b1;
    trig_en = 1'b0;
    do_arm;
    capture(16);
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_count", 32'(count), 32'd16);
    rd_ready = 1'b1;
    chk("bp_pc0", rd_pc, BASE);
    tick;
    rd_ready = 1'b0;
    chk("bp_pc1", rd_pc, BASE + 4);
    tick;
    chk("bp_hold_pc", rd_pc, BASE + 4);
    chk("bp_hold_stamp", 32'(rd_stamp), 32'd1);
    chk("bp_hold_count", 32'(count), 32'd15);
    rd_ready = 1'b1;
    tick;
    chk("bp_pc2", rd_pc, BASE + 8);
    chk("bp_count2", 32'(count), 32'd14);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("collide_state", 32'(state), 32'd1);
    chk("collide_count", 32'(count), 32'd0);
    chk("collide_valid", 32'(rd_valid), 32'd0);
    // asynchronous reset while in POST
    mode = 1'b0;
    trig_en = 1'b1;
    trig_pc = BASE + 8;
    capture(4);
    chk("post_state", 32'(state), 32'd2);
    chk("post_trig", 32'(triggered), 32'd1);
    chk("post_count", 32'(count), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(rd_valid), 32'd0);
    chk("async_trig", 32'(triggered), 32'd0);
    #3 rst = 1'b1;
    tick;
    // zero post-trigger window on the second instance
    do_arm;
    capture(3);
    chk("z_state", 32'(z_state), 32'd3);
    chk("z_count", 32'(z_count), 32'd3);
    chk("z_trig", 32'(z_trig), 32'd1);
    chk("z_main_state", 32'(state), 32'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("z_valid", 32'(z_valid), 32'd1);
      chk("z_pc", z_pc, BASE + 4 * 32'(i));
      chk("z_flags", 32'(z_flags), 32'(i));
      tick;
    end
    rd_ready = 1'b0;
    chk("z_end_valid", 32'(z_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
